// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Sequential binary-to-BCD converter (shift-and-add-3, one input
//            bit per clock). Produces a packed 4-digit BCD value for a
//            7-segment display multiplexer. Inputs above 9999 yield 16'hFFFF
//            so the display visibly reads "FFFF".
// Ports    : clk_i    - system clock, rising edge active
//            rst_ni   - asynchronous active-low reset
//            start_i  - conversion request, honoured only while idle
//            bin_i    - unsigned binary value, sampled on the accepting edge
//            busy_o   - high while a conversion is in progress
//            done_o   - one-cycle pulse, bcd_o/ovf_o just updated
//            ovf_o    - last converted input exceeded 9999
//            bcd_o    - packed BCD result, digit3 in [15:12]
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o,
    output logic [15:0]      bcd_o
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    logic [BIN_W-1:0]   sr_q,   sr_d;
    logic [15:0]        wbcd_q, wbcd_d;
    logic [15:0]        adj;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic               rovf_q;
    logic               busy_q, done_q, ovf_q;
    logic [15:0]        bcd_q;

    // Add-3 is applied to the pre-shift digits; each digit is handled
    // independently with no carry into its neighbour.
    always_comb begin
        adj = wbcd_q;
        for (int i = 0; i < 4; i++) begin
            if (wbcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = wbcd_q[4*i +: 4] + 4'd3;
        end
        // The adjusted top bit falls off the end of the shift; for legal
        // inputs it is always zero at that point.
        wbcd_d = 16'({adj, sr_q[BIN_W-1]});
        sr_d   = sr_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            wbcd_q  <= '0;
            cnt_q   <= '0;
            rovf_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        sr_q    <= bin_i;
                        wbcd_q  <= '0;
                        // Range flag is latched up front; the conversion
                        // still runs all BIN_W cycles to keep latency fixed.
                        rovf_q  <= (32'(bin_i) > 32'd9999);
                        cnt_q   <= CNT_W'(BIN_W);
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sr_q   <= sr_d;
                    wbcd_q <= wbcd_d;
                    cnt_q  <= cnt_d;
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q   <= rovf_q ? 16'hFFFF : wbcd_d;
                        ovf_q   <= rovf_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign ovf_o  = ovf_q;
    assign bcd_o  = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Purpose  : Self-checking bench for bin_to_bcd_seq (BIN_W = 14).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 14;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy, done, ovf;
    logic [15:0]      bcd;

    int tests;
    int fails;

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy),
        .done_o  (done),
        .ovf_o   (ovf),
        .bcd_o   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal reference built from division, independent of the shift algorithm.
    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'hFFFF;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Called just after the accepting edge; counts edges until done is seen.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = busy ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            lat++;
            if (done) break;
            if (busy) busy_cycles++;
        end
        if (!done) lat = -1;
    endtask

    task automatic convert(input int v, input string name, input logic pulse_mid);
        int lat, bc;
        start = 1'b1;
        bin   = BIN_W'(v);
        tick();
        start = 1'b0;
        bin   = '0;
        if (pulse_mid) begin
            lat = 0;
            bc  = 1;
            for (int i = 0; i < 30; i++) begin
                start = (i == 3 || i == 8 || i == 12);
                bin   = BIN_W'(1111 * (i + 1));
                tick();
                lat++;
                if (done) break;
                if (busy) bc++;
            end
            start = 1'b0;
            if (!done) lat = -1;
        end else begin
            wait_done(lat, bc);
        end
        tests++;
        if (lat !== BIN_W) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, BIN_W);
        end
        tests++;
        if (bc !== BIN_W) begin
            fails++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, bc, BIN_W);
        end
        tests++;
        if (bcd !== ref_bcd(v)) begin
            fails++;
            $display("FAIL %s bcd: got %h expected %h", name, bcd, ref_bcd(v));
        end
        tests++;
        if (ovf !== (v > 9999)) begin
            fails++;
            $display("FAIL %s ovf: got %b expected %b", name, ovf, (v > 9999));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) tick();
        tests++;
        if ({busy, done, ovf, bcd} !== 19'h0) begin
            fails++;
            $display("FAIL reset outputs: got busy=%b done=%b ovf=%b bcd=%h expected all zero",
                     busy, done, ovf, bcd);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL reset release: got busy=%b done=%b expected 0 0", busy, done);
        end
        convert(0, "zero", 1'b0);
    endtask

    task automatic test_basic();
        convert(1234, "1234", 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (bcd !== 16'h1234 || done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL hold1234: got bcd=%h done=%b busy=%b expected 1234 0 0",
                         bcd, done, busy);
            end
        end
        // start pulses during SHIFT must neither restart nor queue a conversion
        convert(2468, "mid_pulse", 1'b1);
        repeat (20) begin
            tick();
            tests++;
            if (busy !== 1'b0 || bcd !== 16'h2468) begin
                fails++;
                $display("FAIL no_queue: got busy=%b bcd=%h expected 0 2468", busy, bcd);
            end
        end
    endtask

    task automatic test_range();
        convert(9999,  "9999",  1'b0);
        convert(10000, "10000", 1'b0);
        convert(16383, "16383", 1'b0);
        convert(42,    "42",    1'b0);
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        start = 1'b1;
        bin   = BIN_W'(5);
        tick();
        bin   = BIN_W'(870);
        wait_done(lat, bc);
        tests++;
        if (lat !== BIN_W || bcd !== 16'h0005) begin
            fails++;
            $display("FAIL b2b_first: got lat=%0d bcd=%h expected %0d 0005", lat, bcd, BIN_W);
        end
        bin = BIN_W'(3);
        tick();
        bin = BIN_W'(870);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
        end
        wait_done(lat, bc);
        start = 1'b0;
        tests++;
        if (lat !== BIN_W || bcd !== 16'h0003 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: got lat=%0d bcd=%h ovf=%b expected %0d 0003 0",
                     lat, bcd, ovf, BIN_W);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        convert(7, "7", 1'b0);
        start = 1'b1;
        bin   = BIN_W'(5678);
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, ovf, bcd} !== 19'h0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b ovf=%b bcd=%h expected all zero",
                     busy, done, ovf, bcd);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (done || busy) seen++;
        end
        tests++;
        if (seen !== 0 || bcd !== 16'h0000) begin
            fails++;
            $display("FAIL reset_mid_quiet: got activity=%0d bcd=%h expected 0 0000", seen, bcd);
        end
        convert(31, "31", 1'b0);
    endtask

    // Strided sweep with boundary points, run back-to-back with bcd stability checks.
    task automatic test_sweep();
        int vals[$];
        logic [15:0] prev;
        int lat;
        for (int v = 0; v < 16384; v += 11) vals.push_back(v);
        vals.push_back(9998);
        vals.push_back(9999);
        vals.push_back(10000);
        vals.push_back(16383);
        prev = bcd;
        foreach (vals[k]) begin
            start = 1'b1;
            bin   = BIN_W'(vals[k]);
            tick();
            start = 1'b0;
            lat = 0;
            for (int i = 0; i < 30; i++) begin
                if (done) break;
                tests++;
                if (bcd !== prev) begin
                    fails++;
                    $display("FAIL sweep_stable v=%0d: got %h expected %h", vals[k], bcd, prev);
                end
                tick();
                lat++;
            end
            tests++;
            if (lat !== BIN_W || bcd !== ref_bcd(vals[k]) || ovf !== (vals[k] > 9999)) begin
                fails++;
                $display("FAIL sweep v=%0d: got lat=%0d bcd=%h ovf=%b expected %0d %h %b",
                         vals[k], lat, bcd, ovf, BIN_W, ref_bcd(vals[k]), (vals[k] > 9999));
            end
            prev = ref_bcd(vals[k]);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
